// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_rx_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-FIFO write port plus status pulses; master is the receiver side.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  fifo_full;
  logic                  frame_err;
  logic                  parity_err;
  logic                  overrun_err;
  logic                  busy;

  modport master (
    output wr_en, wr_data, frame_err, parity_err, overrun_err, busy,
    input  fifo_full
  );

  modport slave (
    input  wr_en, wr_data, frame_err, parity_err, overrun_err, busy,
    output fifo_full
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running sample-tick generator: one tick every max(baud_div,1) clocks.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 restart,
  output logic                 tick
);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] last;

  always_comb begin
    last  = (baud_div == '0) ? '0 : baud_div - ONE;
    tick  = !restart && (cnt_q == last);
    cnt_d = cnt_q + ONE;
    // >= lets a divisor shrunk mid-count wrap instead of running to overflow
    if (restart || cnt_q >= last) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start/data/parity/stop decode into a FIFO write strobe.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  uart_rx_if.master            rx_if
);
  localparam int OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  logic sync1_q, sync2_q, rx_prev_q, rx_s;
  rx_state_e state_q, state_d;
  logic [OS_W-1:0]       os_q, os_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, wr_data_q, wr_data_d;
  logic par_mis_q, par_mis_d;
  logic wr_en_q, wr_en_d, ferr_q, ferr_d, perr_q, perr_d, oerr_q, oerr_d;
  logic tick, start_det, sample;

  assign rx_s      = sync2_q;
  assign start_det = (state_q == ST_IDLE) && rx_prev_q && !rx_s;
  // START samples half a bit in; every later state samples a full bit on
  assign sample    = tick && (os_q == ((state_q == ST_START) ? OS_MID : OS_LAST));

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud_tick (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .restart  (start_det),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      os_q      <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_mis_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      oerr_q    <= 1'b0;
    end else begin
      sync1_q   <= rx_in;
      sync2_q   <= sync1_q;
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_mis_q <= par_mis_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      oerr_q    <= oerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start_det) state_d = ST_START;
      ST_START:     if (sample) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (sample && bit_q == BIT_LAST) state_d = parity_en ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (sample) state_d = ST_STOP;
      ST_STOP:      if (sample) state_d = rx_s ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (rx_s) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    os_d      = os_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_mis_d = par_mis_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    oerr_d    = 1'b0;
    if (state_q == ST_IDLE) begin
      os_d      = '0;
      bit_d     = '0;
      par_mis_d = 1'b0;
    end else if (tick) begin
      os_d = sample ? '0 : os_q + OS_W'(1);
    end
    unique case (state_q)
      ST_DATA: if (sample) begin
        data_d = {rx_s, data_q[DATA_WIDTH-1:1]};
        bit_d  = bit_q + BIT_W'(1);
      end
      ST_PARITY: if (sample) par_mis_d = (rx_s != ((^data_q) ^ parity_odd));
      // framing beats parity, parity beats overrun: only one pulse per frame
      ST_STOP: if (sample) begin
        if (!rx_s)                 ferr_d = 1'b1;
        else if (par_mis_q)        perr_d = 1'b1;
        else if (rx_if.fifo_full)  oerr_d = 1'b1;
        else begin
          wr_en_d   = 1'b1;
          wr_data_d = data_q;
        end
      end
      default: ;
    endcase
  end

  assign rx_if.wr_en       = wr_en_q;
  assign rx_if.wr_data     = wr_data_q;
  assign rx_if.frame_err   = ferr_q;
  assign rx_if.parity_err  = perr_q;
  assign rx_if.overrun_err = oerr_q;
  assign rx_if.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push expected pulses, a monitor pops them.
module tb_uart_rx_core;
  localparam int K_WR = 0, K_FE = 1, K_PE = 2, K_OE = 3, K_MULTI = 9;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_in;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;

  uart_rx_if #(.DATA_WIDTH(8)) rx_if ();

  uart_rx_core #(.DATA_WIDTH(8), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_if      (rx_if)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  last_wr_cyc = -1;
  ev_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    int  n;
    int  kind;
    ev_t e;
    if (!rst) begin
      n = int'(rx_if.wr_en) + int'(rx_if.frame_err) + int'(rx_if.parity_err) + int'(rx_if.overrun_err);
      if (n != 0) begin
        kind = rx_if.wr_en ? K_WR : rx_if.frame_err ? K_FE : rx_if.parity_err ? K_PE : K_OE;
        if (n > 1) kind = K_MULTI;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", kind + 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", kind, e.kind);
          if (kind == K_WR) begin
            check("wr_data", int'(rx_if.wr_data), int'(e.data));
            last_wr_cyc = cyc;
          end
          $display("event kind=%0d data=0x%02h at cycle %0d", kind, rx_if.wr_data, cyc);
        end
      end
    end
  end

  function automatic int bit_clks();
    return ((baud_div == 16'd0) ? 1 : int'(baud_div)) * 16;
  endfunction

  task automatic drive(input logic v, input int ncyc);
    rx_in = v;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_on, input bit par_bit, input bit stop_bit);
    drive(1'b0, bit_clks());
    for (int i = 0; i < 8; i++) drive(d[i], bit_clks());
    if (par_on) drive(par_bit, bit_clks());
    drive(stop_bit, bit_clks());
    drive(1'b1, 2 * bit_clks());
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"}, int'(rx_if.wr_en), 0);
    check({tag, "_wr_data"}, int'(rx_if.wr_data), 0);
    check({tag, "_errs"}, int'({rx_if.frame_err, rx_if.parity_err, rx_if.overrun_err}), 0);
    check({tag, "_busy"}, int'(rx_if.busy), 0);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    rx_in = 1'b1;
    baud_div = 16'd4;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    rx_if.fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    drive(1'b1, 20);

    // 0xA5, no parity, with latency from the start edge
    expect_ev(K_WR, 8'hA5);
    t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_latency", last_wr_cyc - t0, 611);

    // even parity on 0x07 (three ones): bit 0 is wrong, bit 1 is right
    parity_en = 1'b1;
    expect_ev(K_PE, 8'h00);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    expect_ev(K_WR, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    parity_en = 1'b0;

    // stop bit low, then a 5-frame break, then a clean frame
    expect_ev(K_FE, 8'h00);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    expect_ev(K_FE, 8'h00);
    drive(1'b0, 50 * bit_clks());
    drive(1'b1, 2 * bit_clks());
    expect_ev(K_WR, 8'h55);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);

    // overrun, then the same byte accepted
    rx_if.fifo_full = 1'b1;
    expect_ev(K_OE, 8'h00);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    rx_if.fifo_full = 1'b0;
    expect_ev(K_WR, 8'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);

    // divisor 0 behaves as 1
    baud_div = 16'd0;
    expect_ev(K_WR, 8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    baud_div = 16'd4;

    // 2-tick low glitch on idle line
    drive(1'b0, 8);
    check("glitch_busy_start", int'(rx_if.busy), 1);
    drive(1'b1, 40);
    check("glitch_busy_end", int'(rx_if.busy), 0);
    drive(1'b1, 2 * bit_clks());

    // reset during data bit 3
    drive(1'b0, bit_clks());
    drive(1'b1, bit_clks());
    drive(1'b1, bit_clks());
    drive(1'b0, bit_clks());
    drive(1'b0, bit_clks() / 2);
    check("midframe_busy", int'(rx_if.busy), 1);
    rx_in = 1'b1;
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 2 * bit_clks());
    check("post_rst_busy", int'(rx_if.busy), 0);
    expect_ev(K_WR, 8'hC3);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);

    drive(1'b1, 100);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, payload bits per frame; OVERSAMPLE, default 16, sample ticks per bit; DIV_WIDTH, default 16, baud divisor width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 rx_in  in  1  asynchronous serial line, idle high.
REQ-006 baud_div  in  DIV_WIDTH  clocks per sample tick; value 0 SHALL be treated as 1.
REQ-007 parity_en  in  1  parity bit present after data when 1.
REQ-008 parity_odd  in  1  odd parity when 1, even when 0.
REQ-009 fifo_full  in  1  downstream RX FIFO full flag.
REQ-010 wr_en  out  1  one-cycle write strobe to downstream RX FIFO.
REQ-011 wr_data  out  DATA_WIDTH  received byte, valid while wr_en=1.
REQ-012 frame_err / parity_err / overrun_err  out  1 each  one-cycle error pulses.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 rx_in SHALL pass a 2-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-015 A tick counter SHALL pulse sample_tick for one clk every max(baud_div,1) clocks, free-running, restarting at 0 on start detect.
REQ-016 States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-017 IDLE -> START on synchronized high-to-low transition; oversample counter cleared.
REQ-018 Mid-bit sample SHALL occur at oversample count OVERSAMPLE/2-1 for START, then every OVERSAMPLE ticks thereafter.
REQ-019 START: mid sample high -> IDLE (glitch rejected, no pulses); low -> DATA.
REQ-020 DATA: DATA_WIDTH mid samples, LSB first, shifted into a data register; then PARITY if parity_en else STOP.
REQ-021 PARITY: computed parity (XOR of data, inverted if parity_odd) SHALL be compared with the sample; mismatch latched.
REQ-022 STOP, sample high, no parity mismatch, fifo_full=0: wr_en=1 for exactly one clk with wr_data = data; -> IDLE.
REQ-023 STOP, sample high, fifo_full=1: overrun_err pulse, byte dropped, no wr_en; -> IDLE.
REQ-024 STOP, sample high, parity mismatch: parity_err pulse, no wr_en; -> IDLE.
REQ-025 STOP, sample low: frame_err pulse, no wr_en, no other pulse; -> WAIT_IDLE.
REQ-026 WAIT_IDLE -> IDLE only once synchronized line is high; a held-low break SHALL produce exactly one frame_err.
REQ-027 Pulses SHALL occur the clk after the stop-bit mid sample; wr_data SHALL hold its value until the next write.
REQ-028 baud_div, parity_en, parity_odd changes mid-frame: undefined frame result, but FSM SHALL return to IDLE within one frame time.

Reset
REQ-029 On rst: state IDLE, counters 0, synchronizer flops 1, wr_en=0, wr_data=0, all error pulses 0, busy=0.
REQ-030 rst mid-frame SHALL abort the frame immediately with no wr_en or error pulse on release.

Structure
REQ-031 Package uart_rx_pkg SHALL hold the state enum and OVERSAMPLE default.
REQ-032 Tick generation SHALL be sub-module uart_baud_tick (clk, rst, baud_div, restart, tick).

Verification
REQ-033 baud_div=4, no parity, frame 0xA5 -> one wr_en with wr_data=0xA5, ~611 clk after falling edge, no errors.
REQ-034 parity_en=1, parity_odd=0, 0x07 with parity bit 0 -> parity_err once, no wr_en; parity bit 1 -> wr_en, 0x07.
REQ-035 Stop bit driven 0 for 0x3C -> frame_err once; line held low 5 frames -> still one frame_err, then 0x55 received correctly.
REQ-036 fifo_full=1 during 0x81 -> overrun_err once, no wr_en; fifo_full=0 then 0x81 -> wr_en, 0x81.
REQ-037 Low glitch of 2 ticks on idle line -> no pulses, busy returns 0 by the START mid sample.
REQ-038 rst asserted during DATA bit 3 -> all outputs 0 immediately; next clean 0xC3 frame -> wr_en, 0xC3.
